// File: rtl/gpu_pkg.sv
// Shared constants, register map and FSM encoding for the VRAM fill engine.
package gpu_pkg;

    // Framebuffer geometry and VRAM address width
    localparam int unsigned FB_W   = 200;
    localparam int unsigned FB_H   = 150;
    localparam int unsigned ADDR_W = 15;

    // MMIO register offsets
    localparam logic [2:0] REG_X0     = 3'd0;
    localparam logic [2:0] REG_Y0     = 3'd1;
    localparam logic [2:0] REG_W      = 3'd2;
    localparam logic [2:0] REG_H      = 3'd3;
    localparam logic [2:0] REG_COLOUR = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;

    // CTRL register strobe bits
    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_CLR_BIT   = 1;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_e;

    // Unsigned minimum of two bytes, used for clipping the rectangle extent
    function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Raster address generator for the fill engine. Its counters describe the pixel
// currently on the VRAM port; o_next_addr is the address the port will carry next
// cycle (first pixel when loading, next raster pixel when stepping).
module fill_addr_gen
    import gpu_pkg::*;
#(
    parameter int unsigned P_FB_W   = FB_W,
    parameter int unsigned P_ADDR_W = ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [7:0]          i_x0,
    input  logic [7:0]          i_y0,
    input  logic [7:0]          i_we,
    input  logic [7:0]          i_he,
    output logic [P_ADDR_W-1:0] o_next_addr,
    output logic                o_last
);

    localparam logic [P_ADDR_W-1:0] LP_STRIDE = P_ADDR_W'(P_FB_W);

    logic [7:0]          r_x0;
    logic [7:0]          r_we;
    logic [7:0]          r_he;
    logic [7:0]          r_x;
    logic [7:0]          r_col;
    logic [7:0]          r_row;
    logic [P_ADDR_W-1:0] r_row_base;

    logic [7:0]          w_x_nxt;
    logic [7:0]          w_col_nxt;
    logic [7:0]          w_row_nxt;
    logic [P_ADDR_W-1:0] w_row_base_nxt;
    logic [P_ADDR_W-1:0] w_row_base0;
    logic                w_end_row;

    // The only multiply in the engine: start-of-rectangle row base
    assign w_row_base0 = P_ADDR_W'(i_y0) * LP_STRIDE;

    assign w_end_row = (r_col == (r_we - 8'd1));
    assign o_last    = w_end_row && (r_row == (r_he - 8'd1));

    // Next counter values: load the first pixel, or advance in raster order
    always_comb begin
        w_x_nxt        = r_x;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_row_base_nxt = r_row_base;
        if (i_load) begin
            w_x_nxt        = i_x0;
            w_col_nxt      = 8'd0;
            w_row_nxt      = 8'd0;
            w_row_base_nxt = w_row_base0;
        end else if (i_step) begin
            if (w_end_row) begin
                w_x_nxt        = r_x0;
                w_col_nxt      = 8'd0;
                w_row_nxt      = r_row + 8'd1;
                w_row_base_nxt = r_row_base + LP_STRIDE;
            end else begin
                w_x_nxt        = r_x + 8'd1;
                w_col_nxt      = r_col + 8'd1;
                w_row_nxt      = r_row;
                w_row_base_nxt = r_row_base;
            end
        end else begin
            w_x_nxt        = r_x;
            w_col_nxt      = r_col;
            w_row_nxt      = r_row;
            w_row_base_nxt = r_row_base;
        end
    end

    assign o_next_addr = w_row_base_nxt + P_ADDR_W'(w_x_nxt);

    // Counter and latched-geometry registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0       <= 8'd0;
            r_we       <= 8'd0;
            r_he       <= 8'd0;
            r_x        <= 8'd0;
            r_col      <= 8'd0;
            r_row      <= 8'd0;
            r_row_base <= '0;
        end else begin
            if (i_load) begin
                r_x0 <= i_x0;
                r_we <= i_we;
                r_he <= i_he;
            end
            r_x        <= w_x_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_row_base <= w_row_base_nxt;
        end
    end

endmodule

// File: rtl/vram_fill_engine.sv
// MMIO-programmed rectangle fill engine driving the VRAM write port, one pixel
// per clock in raster order. Register file and FSM live here; raster address
// sequencing is in fill_addr_gen.
module vram_fill_engine #(
    parameter int unsigned FB_W   = gpu_pkg::FB_W,
    parameter int unsigned FB_H   = gpu_pkg::FB_H,
    parameter int unsigned ADDR_W = gpu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mmio_we_i,
    input  logic [2:0]        mmio_addr_i,
    input  logic [7:0]        mmio_data_i,
    output logic [1:0]        status_o,
    output logic              done_o,
    output logic              v_we_o,
    output logic [ADDR_W-1:0] v_addr_o,
    output logic [7:0]        v_data_o
);

    import gpu_pkg::fill_state_e;
    import gpu_pkg::ST_IDLE;
    import gpu_pkg::ST_SETUP;
    import gpu_pkg::ST_FILL;
    import gpu_pkg::ST_DONE;
    import gpu_pkg::REG_X0;
    import gpu_pkg::REG_Y0;
    import gpu_pkg::REG_W;
    import gpu_pkg::REG_H;
    import gpu_pkg::REG_COLOUR;
    import gpu_pkg::REG_CTRL;
    import gpu_pkg::CTRL_START_BIT;
    import gpu_pkg::CTRL_CLR_BIT;
    import gpu_pkg::min_u8;

    localparam logic [7:0] LP_FB_W8 = 8'(FB_W);
    localparam logic [7:0] LP_FB_H8 = 8'(FB_H);

    // Programmed registers (CPU view)
    logic [7:0]        r_reg_x0;
    logic [7:0]        r_reg_y0;
    logic [7:0]        r_reg_w;
    logic [7:0]        r_reg_h;
    logic [7:0]        r_reg_colour;

    // Engine state and registered outputs
    fill_state_e       r_state;
    logic [7:0]        r_colour;
    logic              r_err;
    logic              r_busy;
    logic              r_done;
    logic              r_v_we;
    logic [ADDR_W-1:0] r_v_addr;
    logic [7:0]        r_v_data;

    fill_state_e       w_state_nxt;
    logic              w_start;
    logic              w_clr;
    logic              w_err_nxt;
    logic              w_load;
    logic              w_step;
    logic              w_last;
    logic              w_empty;
    logic [7:0]        w_we;
    logic [7:0]        w_he;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_start = mmio_we_i && (mmio_addr_i == REG_CTRL) && mmio_data_i[CTRL_START_BIT];
    assign w_clr   = mmio_we_i && (mmio_addr_i == REG_CTRL) && mmio_data_i[CTRL_CLR_BIT];

    // Clipped extent; spans are only meaningful when the origin is on-screen,
    // and an off-screen origin forces the empty case anyway
    assign w_we    = min_u8(r_reg_w, LP_FB_W8 - r_reg_x0);
    assign w_he    = min_u8(r_reg_h, LP_FB_H8 - r_reg_y0);
    assign w_empty = (r_reg_x0 >= LP_FB_W8) || (r_reg_y0 >= LP_FB_H8) ||
                     (w_we == 8'd0) || (w_he == 8'd0);

    // Clear is applied before start, so clear+start while busy leaves err set
    assign w_err_nxt = (w_start && (r_state != ST_IDLE)) ? 1'b1 :
                       (w_clr ? 1'b0 : r_err);

    fill_addr_gen #(
        .P_FB_W   (FB_W),
        .P_ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_x0        (r_reg_x0),
        .i_y0        (r_reg_y0),
        .i_we        (w_we),
        .i_he        (w_he),
        .o_next_addr (w_next_addr),
        .o_last      (w_last)
    );

    // Next-state logic and address-generator control
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                w_load = 1'b1;
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_step      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // CPU-visible register file; CTRL bits are strobes and are not stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg_x0     <= 8'd0;
            r_reg_y0     <= 8'd0;
            r_reg_w      <= 8'd0;
            r_reg_h      <= 8'd0;
            r_reg_colour <= 8'd0;
        end else if (mmio_we_i) begin
            case (mmio_addr_i)
                REG_X0:     r_reg_x0     <= mmio_data_i;
                REG_Y0:     r_reg_y0     <= mmio_data_i;
                REG_W:      r_reg_w      <= mmio_data_i;
                REG_H:      r_reg_h      <= mmio_data_i;
                REG_COLOUR: r_reg_colour <= mmio_data_i;
                default:    ;
            endcase
        end
    end

    // FSM state, latched colour and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_colour <= 8'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_colour <= r_reg_colour;
            end
        end
    end

    // Registered outputs, computed from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_v_we   <= 1'b0;
            r_v_addr <= '0;
            r_v_data <= 8'd0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= (w_state_nxt == ST_DONE);
            r_v_we <= (w_state_nxt == ST_FILL);
            if (w_state_nxt == ST_FILL) begin
                r_v_addr <= w_next_addr;
                r_v_data <= w_load ? r_reg_colour : r_colour;
            end
        end
    end

    assign status_o = {r_err, r_busy};
    assign done_o   = r_done;
    assign v_we_o   = r_v_we;
    assign v_addr_o = r_v_addr;
    assign v_data_o = r_v_data;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench: a transaction-level model turns each accepted start into a
// per-cycle schedule of expected outputs; a compare process checks the DUT every cycle.
module tb_vram_fill_engine;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mmio_we = 1'b0;
    logic [2:0]  mmio_addr = 3'd0;
    logic [7:0]  mmio_data = 8'd0;
    logic [1:0]  status_o;
    logic        done_o;
    logic        v_we_o;
    logic [14:0] v_addr_o;
    logic [7:0]  v_data_o;

    vram_fill_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mmio_we_i   (mmio_we),
        .mmio_addr_i (mmio_addr),
        .mmio_data_i (mmio_data),
        .status_o    (status_o),
        .done_o      (done_o),
        .v_we_o      (v_we_o),
        .v_addr_o    (v_addr_o),
        .v_data_o    (v_data_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        we;
        logic [14:0] addr;
        logic [7:0]  data;
    } frame_t;

    frame_t     fq[$];
    frame_t     cur;
    logic [7:0] m_reg[0:4];
    logic       m_err;
    logic [14:0] m_last_addr;
    logic [7:0]  m_last_data;
    int         pix_q[$];

    // All on-screen pixels of the rectangle in raster order, straight from coordinates
    function automatic void gen_pixels(input int x0, input int y0, input int w, input int h);
        pix_q.delete();
        if (x0 < FB_W && y0 < FB_H) begin
            for (int yy = y0; yy < y0 + h && yy < FB_H; yy++)
                for (int xx = x0; xx < x0 + w && xx < FB_W; xx++)
                    pix_q.push_back(yy * FB_W + xx);
        end
    endfunction

    task automatic m_reset();
        fq.delete();
        cur = '0;
        m_err = 1'b0;
        m_last_addr = 15'd0;
        m_last_data = 8'd0;
        for (int i = 0; i < 5; i++) m_reg[i] = 8'd0;
    endtask

    task automatic m_step();
        frame_t f;
        logic st, cl;
        st = mmio_we && (mmio_addr == REG_CTRL) && mmio_data[0];
        cl = mmio_we && (mmio_addr == REG_CTRL) && mmio_data[1];
        if (mmio_we && mmio_addr < 3'd5) m_reg[mmio_addr] = mmio_data;
        if (cl) m_err = 1'b0;
        if (st) begin
            if (cur.busy) m_err = 1'b1;
            else begin
                gen_pixels(int'(m_reg[0]), int'(m_reg[1]), int'(m_reg[2]), int'(m_reg[3]));
                f = '0; f.busy = 1'b1;
                fq.push_back(f);                       // setup cycle
                foreach (pix_q[i]) begin
                    f = '0; f.busy = 1'b1; f.we = 1'b1;
                    f.addr = 15'(pix_q[i]); f.data = m_reg[4];
                    fq.push_back(f);
                end
                f = '0; f.busy = 1'b1; f.done = 1'b1;
                fq.push_back(f);                       // done cycle
            end
        end
        if (fq.size() != 0) cur = fq.pop_front();
        else cur = '0;
        if (cur.we) begin
            m_last_addr = cur.addr;
            m_last_data = cur.data;
        end else begin
            cur.addr = m_last_addr;
            cur.data = m_last_data;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- compare + observation ----------------
    int obs_addr[$];
    int obs_data[$];
    int obs_cyc[$];
    int last_done_cyc = -1;

    initial begin
        forever begin
            @(negedge clk);
            chk("status", 32'(status_o), 32'({m_err, cur.busy}));
            chk("done",   32'(done_o),   32'(cur.done));
            chk("v_we",   32'(v_we_o),   32'(cur.we));
            chk("v_addr", 32'(v_addr_o), 32'(cur.addr));
            chk("v_data", 32'(v_data_o), 32'(cur.data));
            if (v_we_o === 1'b1) begin
                obs_addr.push_back(int'(v_addr_o));
                obs_data.push_back(int'(v_data_o));
                obs_cyc.push_back(cyc);
            end
            if (done_o === 1'b1) last_done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    int last_wr_cyc = 0;

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        mmio_we = 1'b1; mmio_addr = a; mmio_data = d;
        last_wr_cyc = cyc;
        @(posedge clk); #1;
        mmio_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k;
        k = 0;
        while ((cur.busy || fq.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk(name, 32'(k < budget), 32'd1);
    endtask

    task automatic set_rect(input int x0, input int y0, input int w, input int h, input int col);
        wr(REG_X0, 8'(x0)); wr(REG_Y0, 8'(y0));
        wr(REG_W, 8'(w));   wr(REG_H, 8'(h));
        wr(REG_COLOUR, 8'(col));
    endtask

    int rect_exp[6] = '{1010, 1011, 1012, 1210, 1211, 1212};

    initial begin
        int base, n, k;

        // Pin the model against hand-computed rectangles
        gen_pixels(10, 5, 3, 2);
        chk("model_rect_cnt", 32'(pix_q.size()), 32'd6);
        chk("model_rect_last", 32'(pix_q[5]), 32'd1212);
        gen_pixels(198, 149, 4, 3);
        chk("model_clip_cnt", 32'(pix_q.size()), 32'd2);
        chk("model_clip_first", 32'(pix_q[0]), 32'd29998);

        // Reset held
        repeat (5) @(negedge clk);
        chk("rst_status", 32'(status_o), 32'd0);
        chk("rst_we", 32'(v_we_o), 32'd0);
        chk("rst_addr", 32'(v_addr_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_status", 32'(status_o), 32'd0);

        // Basic rectangle
        set_rect(10, 5, 3, 2, 8'hE0);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        n = last_wr_cyc;
        wait_idle(100, "rect_timeout");
        chk("rect_cnt", 32'(obs_addr.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("rect_addr", 32'(obs_addr[base + i]), 32'(rect_exp[i]));
            chk("rect_data", 32'(obs_data[base + i]), 32'hE0);
        end
        chk("rect_first_lat", 32'(obs_cyc[base] - n), 32'd2);
        chk("rect_done_lat", 32'(last_done_cyc - n), 32'd8);

        // Clipped at the bottom-right corner
        set_rect(198, 149, 4, 3, 8'h1C);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        wait_idle(100, "clip_timeout");
        chk("clip_cnt", 32'(obs_addr.size() - base), 32'd2);
        chk("clip_a0", 32'(obs_addr[base]), 32'd29998);
        chk("clip_a1", 32'(obs_addr[base + 1]), 32'd29999);

        // Empty: zero width, then off-screen origin
        set_rect(10, 5, 0, 2, 8'h55);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        n = last_wr_cyc;
        wait_idle(50, "empty_w_timeout");
        chk("empty_w_cnt", 32'(obs_addr.size() - base), 32'd0);
        chk("empty_w_done", 32'(last_done_cyc - n), 32'd2);
        set_rect(200, 5, 3, 2, 8'h55);
        wr(REG_CTRL, 8'h01);
        n = last_wr_cyc;
        wait_idle(50, "empty_x_timeout");
        chk("empty_x_cnt", 32'(obs_addr.size() - base), 32'd0);
        chk("empty_x_done", 32'(last_done_cyc - n), 32'd2);

        // Full screen with a start while busy, then clear
        set_rect(0, 0, 200, 150, 8'h03);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        repeat (20) @(posedge clk);
        wr(REG_CTRL, 8'h01);
        @(negedge clk);
        chk("busy_err", 32'(status_o), 32'd3);
        wait_idle(31000, "full_timeout");
        chk("full_cnt", 32'(obs_addr.size() - base), 32'd30000);
        chk("full_last", 32'(obs_addr[obs_addr.size() - 1]), 32'd29999);
        chk("err_sticky", 32'(status_o), 32'd2);
        wr(REG_CTRL, 8'h02);
        @(negedge clk);
        chk("err_clr", 32'(status_o), 32'd0);

        // Colour rewritten during a fill
        set_rect(0, 0, 20, 1, 8'h11);
        wr(REG_CTRL, 8'h01);
        wr(REG_COLOUR, 8'h22);
        wait_idle(100, "col_timeout");
        chk("col_old", 32'(obs_data[obs_data.size() - 1]), 32'h11);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        wait_idle(100, "col2_timeout");
        chk("col_new", 32'(obs_data[base]), 32'h22);

        // Asynchronous reset at pixel 100
        set_rect(0, 0, 200, 2, 8'h77);
        base = obs_addr.size();
        wr(REG_CTRL, 8'h01);
        k = 0;
        while (obs_addr.size() - base < 100 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        chk("rst_mid_reach", 32'(obs_addr.size() - base), 32'd100);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(v_we_o), 32'd0);
        chk("rst_mid_status", 32'(status_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = obs_addr.size();
        repeat (30) @(negedge clk);
        chk("rst_no_writes", 32'(obs_addr.size() - base), 32'd0);

        // Randomized rectangles, some with clear, stray writes and busy starts
        for (int it = 0; it < 40; it++) begin
            set_rect($urandom_range(0, 205), $urandom_range(0, 155),
                     $urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 255));
            wr(REG_CTRL, ($urandom_range(0, 3) == 0) ? 8'h03 : 8'h01);
            if ($urandom_range(0, 2) == 0) wr(3'($urandom_range(0, 7)), 8'($urandom));
            wait_idle(2000, "rand_timeout");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
